sda_kernel_ctrl_axi_bridge: RTL
===============================

# sda_kernel_ctrl_axi_bridge

Converts the kernel's AXI4-Lite control slave port into the simple register request/acknowledge bus used by the kernel control register blocks, including the parameter RAM. Those blocks run in parallel, and their regAck/regRData outputs are ORed and returned here. The bridge handles one transaction at a time. It guarantees the regReq low gap between transactions that the downstream blocks need for rising-edge detection.

## Interface
- RegAddrWidth, 12: width of the AXI address and of regAddr
- TimeoutCycles, 255: cycles in REQ without regAck before an error response (used only with the timeout feature); 8-bit counter range, 1..255
- clk  in  1  clock
- srst  in  1  synchronous active-high reset
- s_awvalid/s_awready  in/out  1  write address handshake
- s_awaddr  in  RegAddrWidth  write byte address
- s_wvalid/s_wready  in/out  1  write data handshake
- s_wdata  in  32  write data
- s_wstrb  in  4  byte strobes
- s_bvalid/s_bready  out/in  1  write response handshake
- s_bresp  out  2  write response code
- s_arvalid/s_arready  in/out  1  read address handshake
- s_araddr  in  RegAddrWidth  read byte address
- s_rvalid/s_rready  out/in  1  read data handshake
- s_rdata  out  32  read data
- s_rresp  out  2  read response code
- regReq  out  1  request, held high until acknowledged
- regAck  in  1  single-cycle acknowledge (ORed from slaves)
- regWriteEn  out  1  1 = write, 0 = read
- regAddr  out  RegAddrWidth  byte address, passed through unmodified
- regWData  out  32  write data
- regWStrb  out  4  write strobes
- regRData  in  32  read data, valid on the regAck cycle

## Operation
- FSM states:
  - IDLE
  - WREQ
  - RREQ
  - WRESP
  - RRESP
- IDLE, address/data capture:
  - s_awready is high while no AW is held; s_wready is high while no W is held.
  - AW and W are captured independently and may arrive in any order or together.
- IDLE, read acceptance: s_arready is high only while neither AW nor W is held.
- IDLE transitions:
  - Both AW and W held → WREQ.
  - Otherwise, AR handshake → RREQ.
  - An AR and AW/W presented in the same cycle: the write wins and the AR waits.
- WREQ/RREQ bus drive:
  - regReq = 1; regWriteEn, regAddr, regWData and regWStrb are stable.
  - For a read, regWData and regWStrb are 0.
- WREQ/RREQ on regAck = 1:
  - For a read, register regRData into s_rdata.
  - Go to WRESP or RRESP; regReq drops on that same edge.
- WRESP: s_bvalid = 1, s_bresp = OKAY; on s_bready → IDLE.
- RRESP: s_rvalid = 1, s_rresp = OKAY; on s_rready → IDLE.
- Outside WREQ/RREQ, regWriteEn, regAddr, regWData and regWStrb are driven 0.
- regAck seen outside WREQ/RREQ (late or spurious) is ignored.
- Reset in any state:
  - Return to IDLE.
  - Discard held AW/W.
  - Deassert regReq and all valids.

## Timing
- All outputs are registered. Every output is 0 during srst. The ready signals assert on the first cycle after srst deasserts.
- regReq rises in the cycle after the completing AW/W or AR handshake edge.
- bvalid or rvalid rises in the cycle after regAck is sampled.
- regReq is low for at least one full cycle between transactions, because each response state lasts at least one cycle.
- No new address is accepted until the response handshake completes.
- Latency against the parameter RAM (which acks a write 2 cycles and a read 4 cycles after regReq rises):
  - AW/W handshake at cycle 0 → bvalid at cycle 4.
  - AR handshake at cycle 0 → rvalid at cycle 6.

## Configuration
- SDA_KERNEL_CTRL_AXI_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to WREQ/RREQ and increments each cycle in those states.
  - When it reaches TimeoutCycles without regAck: drop regReq, go to the response state with resp = SLVERR (2'b10) and s_rdata = 0.
  - regAck in the same cycle as the timeout wins, giving OKAY.
- Undefined: no counter; the bridge waits indefinitely for regAck and responses are always OKAY.

## Structure
- Shared package sda_kernel_ctrl_pkg holds:
  - FSM state encoding.
  - AXI response constants: OKAY = 2'b00, SLVERR = 2'b10.
  - Default data width of 32.
- Single flat module; no sub-module is warranted.

## Test plan
- Write to 0x040 with data 0x12345678, strobe 0xF, AW and W in the same cycle; model slave acks 2 cycles after regReq → regWriteEn = 1 and regAddr = 0x040 while regReq is high; bvalid at cycle 4 with bresp = 0.
- W arrives 3 cycles before AW to 0x044 → no regReq until AW is captured; a single write reaches the slave.
- Read 0x040; slave returns 0xCAFEF00D with ack 4 cycles after regReq → rvalid at cycle 6 with rdata = 0xCAFEF00D; regReq stays low ≥1 cycle before the next request.
- AR and AW/W valid in the same cycle → write is issued first, then the read; arready stays low until bvalid/bready completes.
- With the macro defined and TimeoutCycles = 8, the slave never acks → regReq drops after 8 cycles; rresp = 2'b10, rdata = 0; a later ack is ignored.
- srst asserted while in RREQ → regReq and all valids are 0 on the next cycle; a subsequent write completes normally.

Source files
------------

// File: rtl/sda_kernel_ctrl_pkg.sv
// sda_kernel_ctrl_pkg
//   Shared definitions for the kernel control path:
//   - state_t     : AXI bridge FSM state encoding
//   - RESP_OKAY   : AXI response code 2'b00
//   - RESP_SLVERR : AXI response code 2'b10
//   - DATA_W      : default register data width (32)
package sda_kernel_ctrl_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WREQ  = 3'd1,
    ST_RREQ  = 3'd2,
    ST_WRESP = 3'd3,
    ST_RRESP = 3'd4
  } state_t;

endpackage

// File: rtl/sda_kernel_ctrl_axi_bridge.sv
// sda_kernel_ctrl_axi_bridge
//   Bridges the kernel AXI4-Lite control slave port onto the simple
//   regReq/regAck register bus shared by the kernel control register blocks
//   (including the parameter RAM). One transaction is in flight at a time,
//   and regReq always drops for at least one cycle between transactions so
//   downstream blocks can detect its rising edge.
//
//   Ports (all outputs registered, all outputs 0 while srst is high):
//     clk, srst                      clock, synchronous active-high reset
//     s_aw*/s_w*/s_b*                AXI4-Lite write address/data/response
//     s_ar*/s_r*                     AXI4-Lite read address/data
//     regReq, regWriteEn, regAddr,   register bus request (held until ack)
//     regWData, regWStrb
//     regAck, regRData               ORed acknowledge and read data
//
//   Optional feature: define SDA_KERNEL_CTRL_AXI_TIMEOUT_EN to abort a
//   request that sees no regAck within TimeoutCycles cycles, answering
//   SLVERR (read data 0). Without it the bridge waits indefinitely.
module sda_kernel_ctrl_axi_bridge
  import sda_kernel_ctrl_pkg::*;
#(
  parameter int RegAddrWidth  = 12,
  parameter int TimeoutCycles = 255
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [RegAddrWidth-1:0] s_awaddr,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  input  logic [DATA_W-1:0]       s_wdata,
  input  logic [DATA_W/8-1:0]     s_wstrb,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic [1:0]              s_bresp,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  input  logic [RegAddrWidth-1:0] s_araddr,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [DATA_W-1:0]       s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    regReq,
  input  logic                    regAck,
  output logic                    regWriteEn,
  output logic [RegAddrWidth-1:0] regAddr,
  output logic [DATA_W-1:0]       regWData,
  output logic [DATA_W/8-1:0]     regWStrb,
  input  logic [DATA_W-1:0]       regRData
);

  state_t                  r_state;
  logic                    r_aw_held;
  logic                    r_w_held;
  logic                    r_ar_held;
  logic [RegAddrWidth-1:0] r_awaddr;
  logic [RegAddrWidth-1:0] r_araddr;
  logic [DATA_W-1:0]       r_wdata;
  logic [DATA_W/8-1:0]     r_wstrb;

  logic                    r_awready;
  logic                    r_wready;
  logic                    r_arready;
  logic                    r_bvalid;
  logic [1:0]              r_bresp;
  logic                    r_rvalid;
  logic [1:0]              r_rresp;
  logic [DATA_W-1:0]       r_rdata;
  logic                    r_req;
  logic                    r_we;
  logic [RegAddrWidth-1:0] r_addr;
  logic [DATA_W-1:0]       r_wd;
  logic [DATA_W/8-1:0]     r_ws;

  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic                    w_ar_hs;
  logic                    w_aw_held_nx;
  logic                    w_w_held_nx;
  logic [RegAddrWidth-1:0] w_awaddr_nx;
  logic [DATA_W-1:0]       w_wdata_nx;
  logic [DATA_W/8-1:0]     w_wstrb_nx;
  logic                    w_timeout;
  logic                    w_req_done;
  logic [1:0]              w_resp_code;
  logic [DATA_W-1:0]       w_rdata_in;

  assign s_awready  = r_awready;
  assign s_wready   = r_wready;
  assign s_arready  = r_arready;
  assign s_bvalid   = r_bvalid;
  assign s_bresp    = r_bresp;
  assign s_rvalid   = r_rvalid;
  assign s_rresp    = r_rresp;
  assign s_rdata    = r_rdata;
  assign regReq     = r_req;
  assign regWriteEn = r_we;
  assign regAddr    = r_addr;
  assign regWData   = r_wd;
  assign regWStrb   = r_ws;

  // Readies are only ever high in IDLE, so a handshake implies IDLE.
  assign w_aw_hs = s_awvalid & r_awready;
  assign w_w_hs  = s_wvalid  & r_wready;
  assign w_ar_hs = s_arvalid & r_arready;

  // Held state as it will be after this edge, so a write whose last half
  // arrives now can launch without an extra idle cycle.
  assign w_aw_held_nx = r_aw_held | w_aw_hs;
  assign w_w_held_nx  = r_w_held  | w_w_hs;
  assign w_awaddr_nx  = w_aw_hs ? s_awaddr : r_awaddr;
  assign w_wdata_nx   = w_w_hs  ? s_wdata  : r_wdata;
  assign w_wstrb_nx   = w_w_hs  ? s_wstrb  : r_wstrb;

`ifdef SDA_KERNEL_CTRL_AXI_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TimeoutCycles - 1);

  logic [7:0] r_cnt;

  // Held at zero outside the request states, so it starts from zero on
  // every entry; reaching TO_LAST means TimeoutCycles request cycles passed.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_cnt <= '0;
    end else if (r_state == ST_WREQ || r_state == ST_RREQ) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_timeout = (r_cnt == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // An ack in the timeout cycle wins and reports OKAY with real data.
  assign w_req_done  = regAck | w_timeout;
  assign w_resp_code = regAck ? RESP_OKAY : RESP_SLVERR;
  assign w_rdata_in  = regAck ? regRData : '0;

  // Captured AXI payload; only qualified by the held flags, so no reset.
  always_ff @(posedge clk) begin
    if (w_aw_hs) r_awaddr <= s_awaddr;
    if (w_w_hs) begin
      r_wdata <= s_wdata;
      r_wstrb <= s_wstrb;
    end
    if (w_ar_hs) r_araddr <= s_araddr;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_state   <= ST_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_ar_held <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_arready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wd      <= '0;
      r_ws      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_aw_held_nx && w_w_held_nx) begin
            // Write wins; an AR accepted in the same cycle is parked
            // and issued once the write response completes.
            r_state   <= ST_WREQ;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_ar_held <= r_ar_held | w_ar_hs;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_arready <= 1'b0;
            r_req     <= 1'b1;
            r_we      <= 1'b1;
            r_addr    <= w_awaddr_nx;
            r_wd      <= w_wdata_nx;
            r_ws      <= w_wstrb_nx;
          end else if (r_ar_held || w_ar_hs) begin
            r_state   <= ST_RREQ;
            r_aw_held <= w_aw_held_nx;
            r_w_held  <= w_w_held_nx;
            r_ar_held <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_arready <= 1'b0;
            r_req     <= 1'b1;
            r_we      <= 1'b0;
            r_addr    <= r_ar_held ? r_araddr : s_araddr;
            r_wd      <= '0;
            r_ws      <= '0;
          end else begin
            r_aw_held <= w_aw_held_nx;
            r_w_held  <= w_w_held_nx;
            r_awready <= ~w_aw_held_nx;
            r_wready  <= ~w_w_held_nx;
            r_arready <= ~w_aw_held_nx & ~w_w_held_nx;
          end
        end

        ST_WREQ, ST_RREQ: begin
          if (w_req_done) begin
            r_req  <= 1'b0;
            r_we   <= 1'b0;
            r_addr <= '0;
            r_wd   <= '0;
            r_ws   <= '0;
            if (r_state == ST_WREQ) begin
              r_state  <= ST_WRESP;
              r_bvalid <= 1'b1;
              r_bresp  <= w_resp_code;
            end else begin
              r_state  <= ST_RRESP;
              r_rvalid <= 1'b1;
              r_rresp  <= w_resp_code;
              r_rdata  <= w_rdata_in;
            end
          end
        end

        ST_WRESP: begin
          if (s_bready) begin
            r_state   <= ST_IDLE;
            r_bvalid  <= 1'b0;
            r_awready <= ~r_aw_held;
            r_wready  <= ~r_w_held;
            r_arready <= ~r_aw_held & ~r_w_held & ~r_ar_held;
          end
        end

        ST_RRESP: begin
          if (s_rready) begin
            r_state   <= ST_IDLE;
            r_rvalid  <= 1'b0;
            r_awready <= ~r_aw_held;
            r_wready  <= ~r_w_held;
            r_arready <= ~r_aw_held & ~r_w_held & ~r_ar_held;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
